window_scan_ctrl: RTL

WINDOW_SCAN_CTRL -- requirements
Module: window_scan_ctrl

---
 rtl/window_scan_ctrl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/window_scan_ctrl.sv
// Raster scan controller for a stereo window: primes four lines, then tags each accepted pixel column.
// Latency: one cycle from accept to tag. A stalled tag (out_valid && !out_ready) holds in_ready low.
module window_scan_ctrl #(
  parameter int DISP_RANGE = 255,
  parameter int DIM_W      = 11
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             start,
  input  logic [DIM_W-1:0] width,
  input  logic [DIM_W-1:0] height,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             clken,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DIM_W-1:0] out_col,
  output logic [DIM_W-1:0] out_row,
  output logic             out_disp_full,
  output logic             busy,
  output logic             frame_done,
  output logic             cfg_err
);

  localparam int CW = 2*DIM_W + 2;
  localparam logic [CW-1:0] DISP_M1 = CW'(DISP_RANGE - 1);

  typedef enum logic [1:0] {S_IDLE, S_PRIME, S_RUN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [DIM_W-1:0] r_width;
  logic [DIM_W-1:0] r_height;
  logic [DIM_W-1:0] r_col;
  logic [DIM_W-1:0] r_row;
  logic [CW-1:0]    r_cnt;
  logic             r_out_valid;
  logic [DIM_W-1:0] r_out_col;
  logic [DIM_W-1:0] r_out_row;
  logic             r_out_full;
  logic             r_cfg_err;

  logic             w_cfg_ok;
  logic             w_in_ready;
  logic             w_clken;
  logic             w_col_last;
  logic             w_row_last;
  logic             w_prime_last;
  logic             w_disp_full;
  logic             w_frame_done;
  logic             w_busy;

  assign w_cfg_ok     = (width != '0) && (height >= DIM_W'(5));
  assign w_clken      = in_valid && w_in_ready;
  assign w_col_last   = (r_col == r_width - DIM_W'(1));
  assign w_row_last   = (r_row == r_height - DIM_W'(1));
  // Four full lines must be accepted before the window holds valid rows.
  assign w_prime_last = ((r_cnt + CW'(1)) == {{DIM_W{1'b0}}, r_width, 2'b00});
  assign w_disp_full  = ({{(CW-DIM_W){1'b0}}, r_col} >= DISP_M1);

  always_ff @(posedge clock) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    w_in_ready   = 1'b0;
    w_frame_done = 1'b0;
    w_busy       = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (start && w_cfg_ok) w_next = S_PRIME;
      end
      S_PRIME: begin
        w_in_ready = !r_out_valid || out_ready;
        if (in_valid && w_in_ready && w_prime_last) w_next = S_RUN;
      end
      S_RUN: begin
        w_in_ready = !r_out_valid || out_ready;
        if (in_valid && w_in_ready && w_row_last && w_col_last) w_next = S_DONE;
      end
      S_DONE: begin
        if (!r_out_valid) begin
          w_frame_done = 1'b1;
          w_next       = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      r_width     <= '0;
      r_height    <= '0;
      r_col       <= '0;
      r_row       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_col   <= '0;
      r_out_row   <= '0;
      r_out_full  <= 1'b0;
      r_cfg_err   <= 1'b0;
    end else begin
      r_cfg_err <= (r_state == S_IDLE) && start && !w_cfg_ok;
      if ((r_state == S_IDLE) && start && w_cfg_ok) begin
        r_width  <= width;
        r_height <= height;
        r_col    <= '0;
        r_row    <= '0;
        r_cnt    <= '0;
      end
      if (w_clken) begin
        if (w_col_last) begin
          r_col <= '0;
          r_row <= r_row + DIM_W'(1);
        end else begin
          r_col <= r_col + DIM_W'(1);
        end
        if (r_state == S_PRIME) r_cnt <= r_cnt + CW'(1);
      end
      // A new accept replaces a tag leaving in the same cycle, so no bubble.
      if (w_clken && (r_state == S_RUN)) begin
        r_out_valid <= 1'b1;
        r_out_col   <= r_col;
        r_out_row   <= r_row;
        r_out_full  <= w_disp_full;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign in_ready      = w_in_ready;
  assign clken         = w_clken;
  assign out_valid     = r_out_valid;
  assign out_col       = r_out_col;
  assign out_row       = r_out_row;
  assign out_disp_full = r_out_full;
  assign busy          = w_busy;
  assign frame_done    = w_frame_done;
  assign cfg_err       = r_cfg_err;

endmodule
